// File: rtl/router_pkt_tx.sv
// Router input-port packet source: stages payload bytes in a FIFO, then sends
// header, payload and (optionally corrupted) parity while honouring busy.
module router_pkt_tx #(
  parameter int         BUF_DEPTH = 64,
  parameter logic [7:0] INJ_MASK  = 8'h05
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ld_en,
  input  logic [7:0]                 i_ld_data,
  output logic                       o_ld_full,
  output logic [$clog2(BUF_DEPTH):0] o_ld_count,
  input  logic                       i_start,
  input  logic [1:0]                 i_dest_addr,
  input  logic [5:0]                 i_pld_len,
  input  logic                       i_err_inj,
  output logic                       o_start_rej,
  input  logic                       i_busy,
  output logic [7:0]                 o_data_out,
  output logic                       o_pkt_valid,
  output logic                       o_tx_active,
  output logic                       o_done,
  output logic [2:0]                 o_state
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Handshake with the router: a byte is consumed at every rising edge where
  // o_tx_active=1 and i_busy=0; with i_busy=1 every transmit register holds.

  // ---------------- payload FIFO ----------------
  logic [7:0]    r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          w_wr;
  logic          w_rd;
  logic [AW:0]   w_count_nxt;
  logic [7:0]    w_rd_data;

  assign w_wr      = i_ld_en & ~r_full;
  assign w_rd_data = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_ld_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
    end
  end

  // ---------------- transmit FSM ----------------
  state_t     r_state, w_state_nxt;
  logic [7:0] r_data,   w_data_nxt;
  logic       r_valid,  w_valid_nxt;
  logic       r_active, w_active_nxt;
  logic       r_done,   w_done_nxt;
  logic       r_rej,    w_rej_nxt;
  logic [7:0] r_par,    w_par_nxt;
  logic [5:0] r_cnt,    w_cnt_nxt;
  logic [5:0] r_len,    w_len_nxt;
  logic       r_inj,    w_inj_nxt;
  logic       w_accept;
  logic [7:0] w_header;

  assign w_accept = (i_pld_len != 6'd0) && (r_count >= (AW+1)'(i_pld_len));
  assign w_header = {i_pld_len, i_dest_addr};

  // Parity accumulates when a byte is loaded into r_data, so it is complete
  // by the time the last payload byte is accepted.
  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    w_active_nxt = r_active;
    w_done_nxt   = 1'b0;
    w_rej_nxt    = 1'b0;
    w_par_nxt    = r_par;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_inj_nxt    = r_inj;
    w_rd         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_data_nxt   = 8'h00;
        w_valid_nxt  = 1'b0;
        w_active_nxt = 1'b0;
        if (i_start) begin
          if (w_accept) begin
            w_state_nxt  = S_HEADER;
            w_len_nxt    = i_pld_len;
            w_inj_nxt    = i_err_inj;
            w_data_nxt   = w_header;
            w_par_nxt    = w_header;
            w_valid_nxt  = 1'b1;
            w_active_nxt = 1'b1;
            w_cnt_nxt    = 6'd0;
          end else begin
            w_rej_nxt = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (!i_busy) begin
          w_state_nxt = S_PAYLOAD;
          w_data_nxt  = w_rd_data;
          w_par_nxt   = r_par ^ w_rd_data;
          w_cnt_nxt   = 6'd0;
          w_rd        = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (!i_busy) begin
          if (r_cnt == r_len - 6'd1) begin
            w_state_nxt = S_PARITY;
            w_valid_nxt = 1'b0;
            w_data_nxt  = r_par ^ (r_inj ? INJ_MASK : 8'h00);
          end else begin
            w_cnt_nxt  = r_cnt + 6'd1;
            w_data_nxt = w_rd_data;
            w_par_nxt  = r_par ^ w_rd_data;
            w_rd       = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (!i_busy) begin
          w_state_nxt  = S_DONE;
          w_data_nxt   = 8'h00;
          w_valid_nxt  = 1'b0;
          w_active_nxt = 1'b0;
          w_done_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt  = S_IDLE;
        w_data_nxt   = 8'h00;
        w_valid_nxt  = 1'b0;
        w_active_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_data_nxt   = 8'h00;
        w_valid_nxt  = 1'b0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_rej    <= 1'b0;
      r_par    <= 8'h00;
      r_cnt    <= 6'd0;
      r_len    <= 6'd0;
      r_inj    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_active <= w_active_nxt;
      r_done   <= w_done_nxt;
      r_rej    <= w_rej_nxt;
      r_par    <= w_par_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_inj    <= w_inj_nxt;
    end
  end

  assign o_ld_full   = r_full;
  assign o_ld_count  = r_count;
  assign o_start_rej = r_rej;
  assign o_data_out  = r_data;
  assign o_pkt_valid = r_valid;
  assign o_tx_active = r_active;
  assign o_done      = r_done;
  assign o_state     = r_state;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a byte-queue model predicts each packet's byte
// stream, a negedge monitor scores every byte the router would accept.
module tb_router_pkt_tx;
  localparam int         DEPTH = 64;
  localparam logic [7:0] MASK  = 8'h05;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ld_en, start, err_inj, busy;
  logic [7:0] ld_data;
  logic [1:0] dest_addr;
  logic [5:0] pld_len;
  logic       ld_full, start_rej, pkt_valid, tx_active, done;
  logic [6:0] ld_count;
  logic [7:0] data_out;
  logic [2:0] state;

  router_pkt_tx #(.BUF_DEPTH(DEPTH), .INJ_MASK(MASK)) dut (
    .i_clk(clk), .i_rst(rst), .i_ld_en(ld_en), .i_ld_data(ld_data),
    .o_ld_full(ld_full), .o_ld_count(ld_count), .i_start(start),
    .i_dest_addr(dest_addr), .i_pld_len(pld_len), .i_err_inj(err_inj),
    .o_start_rej(start_rej), .i_busy(busy), .o_data_out(data_out),
    .o_pkt_valid(pkt_valid), .o_tx_active(tx_active), .o_done(done),
    .o_state(state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int par_cyc = 0;
  int t_start = 0;
  bit mon_en = 1'b0;
  bit busy_rand = 1'b0;

  logic [7:0] mq[$];     // bytes staged in the FIFO, oldest first
  logic [8:0] exp_q[$];  // {pkt_valid, data_out} expected per accepted byte

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [8:0] mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_active && !busy) begin
        if (exp_q.size() == 0) begin
          check("stray_byte", 32'(tx_active), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_byte", 32'({pkt_valid, data_out}), 32'(mon_e));
          if (!mon_e[8]) par_cyc = cyc;
        end
      end
      if (!tx_active) check("idle_valid", 32'(pkt_valid), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy_rand) busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic load(input logic [7:0] b);
    ld_en   = 1'b1;
    ld_data = b;
    if (mq.size() < DEPTH) mq.push_back(b);
    tick();
    ld_en = 1'b0;
  endtask

  task automatic start_pkt(input logic [1:0] addr, input logic [5:0] len,
                           input logic inj, output bit acc);
    bit         acc_e;
    logic [7:0] hdr;
    logic [7:0] par;
    acc_e = (len != 6'd0) && (mq.size() >= int'(len));
    hdr   = {len, addr};
    if (acc_e) begin
      exp_q.push_back({1'b1, hdr});
      par = hdr;
      for (int i = 0; i < int'(len); i++) begin
        exp_q.push_back({1'b1, mq[i]});
        par ^= mq[i];
      end
      exp_q.push_back({1'b0, inj ? (par ^ MASK) : par});
    end
    start = 1'b1; dest_addr = addr; pld_len = len; err_inj = inj;
    tick();
    start = 1'b0;
    t_start = cyc;
    @(negedge clk);
    check("start_rej", 32'(start_rej), 32'(!acc_e));
    if (acc_e) check("header", 32'({pkt_valid, data_out}), 32'({1'b1, hdr}));
    else       check("rej_idle", 32'(tx_active), 32'd0);
    acc = acc_e;
  endtask

  task automatic wait_done(input int len, input bit load_mid);
    int d0;
    int c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < 400) begin
      if (load_mid && mq.size() < 60 && $urandom_range(0, 2) == 0) begin
        ld_en   = 1'b1;
        ld_data = 8'($urandom);
        mq.push_back(ld_data);
      end else begin
        ld_en = 1'b0;
      end
      tick();
      c++;
    end
    ld_en = 1'b0;
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < len; i++) void'(mq.pop_front());
    @(negedge clk);
    check("ld_count_after", 32'(ld_count), 32'(mq.size()));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  bit         acc;
  logic [7:0] b3;
  int         d0;
  int         n;
  logic [5:0] rlen;

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_data = 8'h00; start = 1'b0;
    dest_addr = 2'd0; pld_len = 6'd0; err_inj = 1'b0; busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(pkt_valid), 32'd0);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rej", 32'(start_rej), 32'd0);
    check("rst_count", 32'(ld_count), 32'd0);
    check("rst_full", 32'(ld_full), 32'd0);
    mon_en = 1'b1;

    // start with an empty FIFO is rejected
    start_pkt(2'd0, 6'd5, 1'b0, acc);

    // good packet with cycle timing
    for (int i = 0; i < 8; i++) load(8'($urandom));
    @(negedge clk);
    check("count_8", 32'(ld_count), 32'd8);
    start_pkt(2'd0, 6'd8, 1'b0, acc);
    wait_done(8, 1'b0);
    check("par_time", 32'(par_cyc - t_start), 32'd9);
    check("done_time", 32'(done_cyc - t_start), 32'd10);

    // error injection
    for (int i = 0; i < 5; i++) load(8'($urandom));
    start_pkt(2'd2, 6'd5, 1'b1, acc);
    wait_done(5, 1'b0);

    // back-pressure on payload byte 3
    for (int i = 0; i < 8; i++) load(8'($urandom));
    b3 = mq[3];
    start_pkt(2'd1, 6'd8, 1'b0, acc);
    tick(); tick(); tick(); tick();
    busy = 1'b1;
    @(negedge clk); check("bp_hold0", 32'(data_out), 32'(b3));
    tick(); @(negedge clk); check("bp_hold1", 32'(data_out), 32'(b3));
    tick(); @(negedge clk); check("bp_hold2", 32'(data_out), 32'(b3));
    tick(); busy = 1'b0;
    @(negedge clk); check("bp_hold3", 32'(data_out), 32'(b3));
    wait_done(8, 1'b0);
    check("bp_par_time", 32'(par_cyc - t_start), 32'd12);
    check("bp_done_time", 32'(done_cyc - t_start), 32'd13);

    // rejections, then a packet with loads during transmit
    for (int i = 0; i < 3; i++) load(8'($urandom));
    start_pkt(2'd1, 6'd0, 1'b0, acc);
    load(8'($urandom));
    start_pkt(2'd3, 6'd6, 1'b0, acc);
    start_pkt(2'd3, 6'd4, 1'b0, acc);
    wait_done(4, 1'b1);
    if (mq.size() > 0) begin
      n = mq.size();
      start_pkt(2'd0, 6'(n), 1'b0, acc);
      wait_done(n, 1'b0);
    end

    // FIFO fill limit
    for (int i = 0; i < 63; i++) load(8'(i + 1));
    @(negedge clk);
    check("full_63", 32'(ld_full), 32'd0);
    load(8'd64);
    @(negedge clk);
    check("full_64", 32'(ld_full), 32'd1);
    check("count_64", 32'(ld_count), 32'd64);
    load(8'hEE);
    @(negedge clk);
    check("count_65", 32'(ld_count), 32'd64);
    busy_rand = 1'b1;
    start_pkt(2'd0, 6'd63, 1'b0, acc);
    wait_done(63, 1'b0);
    start_pkt(2'd1, 6'd1, 1'b0, acc);
    wait_done(1, 1'b0);
    busy_rand = 1'b0;
    busy = 1'b0;

    // reset while payload byte 2 is presented
    for (int i = 0; i < 6; i++) load(8'($urandom));
    start_pkt(2'd2, 6'd6, 1'b0, acc);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(pkt_valid), 32'd0);
    check("mrst_active", 32'(tx_active), 32'd0);
    check("mrst_count", 32'(ld_count), 32'd0);
    mq.delete();
    exp_q.delete();
    d0 = done_cnt;
    repeat (8) tick();
    check("mrst_no_done", 32'(done_cnt), 32'(d0));
    for (int i = 0; i < 4; i++) load(8'($urandom));
    start_pkt(2'd3, 6'd4, 1'b1, acc);
    wait_done(4, 1'b0);

    // randomized packets under random back-pressure
    busy_rand = 1'b1;
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) if (mq.size() < 55) load(8'($urandom));
      rlen = 6'($urandom_range(0, 20));
      start_pkt(2'($urandom), rlen, 1'($urandom), acc);
      if (acc) wait_done(int'(rlen), 1'b1);
    end
    busy_rand = 1'b0;
    busy = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (state=%0d)", state);
    $fatal(1, "watchdog");
  end

endmodule
